// File: rtl/dma_client_axis_sink_q.sv
// AXI-stream to segmented-RAM DMA write client with a descriptor queue.
// One stream frame is consumed per descriptor; a status pulse reports count, sideband and error.
module dma_client_axis_sink_q #(
    parameter int SEG_COUNT       = 2,
    parameter int SEG_DATA_WIDTH  = 64,
    parameter int SEG_ADDR_WIDTH  = 8,
    parameter int SEG_BE_WIDTH    = SEG_DATA_WIDTH / 8,
    parameter int RAM_ADDR_WIDTH  = SEG_ADDR_WIDTH + $clog2(SEG_COUNT) + $clog2(SEG_BE_WIDTH),
    parameter int AXIS_DATA_WIDTH = SEG_DATA_WIDTH * SEG_COUNT / 2,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_ID_WIDTH   = 8,
    parameter int AXIS_DEST_WIDTH = 8,
    parameter int AXIS_USER_WIDTH = 1,
    parameter int LEN_WIDTH       = 16,
    parameter int TAG_WIDTH       = 8,
    parameter int DESC_FIFO_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic [RAM_ADDR_WIDTH-1:0]              s_axis_write_desc_ram_addr,
    input  logic [LEN_WIDTH-1:0]                   s_axis_write_desc_len,
    input  logic [TAG_WIDTH-1:0]                   s_axis_write_desc_tag,
    input  logic                                   s_axis_write_desc_valid,
    output logic                                   s_axis_write_desc_ready,

    output logic [LEN_WIDTH-1:0]                   m_axis_write_desc_status_len,
    output logic [TAG_WIDTH-1:0]                   m_axis_write_desc_status_tag,
    output logic [AXIS_ID_WIDTH-1:0]               m_axis_write_desc_status_id,
    output logic [AXIS_DEST_WIDTH-1:0]             m_axis_write_desc_status_dest,
    output logic [AXIS_USER_WIDTH-1:0]             m_axis_write_desc_status_user,
    output logic [3:0]                             m_axis_write_desc_status_error,
    output logic                                   m_axis_write_desc_status_valid,

    input  logic [AXIS_DATA_WIDTH-1:0]             s_axis_write_data_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]             s_axis_write_data_tkeep,
    input  logic                                   s_axis_write_data_tvalid,
    output logic                                   s_axis_write_data_tready,
    input  logic                                   s_axis_write_data_tlast,
    input  logic [AXIS_ID_WIDTH-1:0]               s_axis_write_data_tid,
    input  logic [AXIS_DEST_WIDTH-1:0]             s_axis_write_data_tdest,
    input  logic [AXIS_USER_WIDTH-1:0]             s_axis_write_data_tuser,

    output logic [SEG_COUNT*SEG_BE_WIDTH-1:0]      ram_wr_cmd_be,
    output logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0]    ram_wr_cmd_addr,
    output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]    ram_wr_cmd_data,
    output logic [SEG_COUNT-1:0]                   ram_wr_cmd_valid,
    input  logic [SEG_COUNT-1:0]                   ram_wr_cmd_ready,

    input  logic                                   enable,
    input  logic                                   abort
);

    localparam int ROW_BITS   = $clog2(SEG_COUNT) + $clog2(SEG_BE_WIDTH);
    localparam int ROW_BYTES  = SEG_COUNT * SEG_BE_WIDTH;
    localparam int ROW_DW     = ROW_BYTES * 8;
    localparam int FIFO_AW    = $clog2(DESC_FIFO_DEPTH);
    localparam int KEEP_CNT_W = $clog2(AXIS_KEEP_WIDTH + 1);
    localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_MASK = ~RAM_ADDR_WIDTH'(AXIS_KEEP_WIDTH - 1);

    localparam logic [3:0] ERR_OK    = 4'd0;
    localparam logic [3:0] ERR_TRUNC = 4'd1;
    localparam logic [3:0] ERR_USER  = 4'd2;
    localparam logic [3:0] ERR_ABORT = 4'd3;

    typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

    state_t state_q, state_d;

    logic [RAM_ADDR_WIDTH-1:0]  fifo_addr_q [DESC_FIFO_DEPTH];
    logic [LEN_WIDTH-1:0]       fifo_len_q  [DESC_FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]       fifo_tag_q  [DESC_FIFO_DEPTH];
    logic [FIFO_AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                       fifo_empty, fifo_full, desc_push, desc_pop;

    logic [RAM_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LEN_WIDTH-1:0]       rem_q, rem_d, cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0]       tag_q, tag_d;
    logic [AXIS_ID_WIDTH-1:0]   id_q, id_d, id_cur;
    logic [AXIS_DEST_WIDTH-1:0] dest_q, dest_d, dest_cur;
    logic [AXIS_USER_WIDTH-1:0] user_q, user_d, user_cur;
    logic                       first_q, first_d;

    logic [LEN_WIDTH-1:0]       st_len_q, st_len_d;
    logic [TAG_WIDTH-1:0]       st_tag_q, st_tag_d;
    logic [AXIS_ID_WIDTH-1:0]   st_id_q, st_id_d;
    logic [AXIS_DEST_WIDTH-1:0] st_dest_q, st_dest_d;
    logic [AXIS_USER_WIDTH-1:0] st_user_q, st_user_d;
    logic [3:0]                 st_err_q, st_err_d;
    logic                       st_valid_q, st_valid_d;

    logic [SEG_COUNT-1:0]                seg_valid_q, seg_valid_d;
    logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   seg_be_q, seg_be_d;
    logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] seg_addr_q, seg_addr_d;
    logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] seg_data_q, seg_data_d;

    logic [AXIS_KEEP_WIDTH-1:0] lane_ok, byte_mask;
    logic [KEEP_CNT_W-1:0]      beat_bytes;
    logic                       trunc, beat, tready, seg_free;
    logic [ROW_BITS-1:0]        row_off;
    logic [SEG_ADDR_WIDTH-1:0]  word_addr;
    logic [ROW_DW-1:0]          wide_data;
    logic [ROW_BYTES-1:0]       wide_be, wide_tgt;
    logic [SEG_COUNT-1:0]       seg_tgt;

    // Descriptor queue
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign s_axis_write_desc_ready = !fifo_full && !rst;
    assign desc_push = s_axis_write_desc_valid && s_axis_write_desc_ready;

    always_comb begin
        wr_ptr_d = desc_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = desc_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (desc_push) begin
            fifo_addr_q[wr_ptr_q[FIFO_AW-1:0]] <= s_axis_write_desc_ram_addr & ADDR_MASK;
            fifo_len_q[wr_ptr_q[FIFO_AW-1:0]]  <= s_axis_write_desc_len;
            fifo_tag_q[wr_ptr_q[FIFO_AW-1:0]]  <= s_axis_write_desc_tag;
        end
    end

    // Beat placement: the beat lands in a row spanning all segments at one word address
    assign row_off   = addr_q[ROW_BITS-1:0];
    assign word_addr = addr_q[RAM_ADDR_WIDTH-1:ROW_BITS];

    always_comb begin
        beat_bytes = '0;
        for (int unsigned i = 0; i < AXIS_KEEP_WIDTH; i++) begin
            lane_ok[i] = (LEN_WIDTH'(i) < rem_q);
        end
        byte_mask = s_axis_write_data_tkeep & lane_ok;
        for (int unsigned i = 0; i < AXIS_KEEP_WIDTH; i++) begin
            beat_bytes = beat_bytes + KEEP_CNT_W'(byte_mask[i]);
        end
        trunc = (|(s_axis_write_data_tkeep & ~lane_ok)) ||
                ((rem_q == '0) && !s_axis_write_data_tlast);
        wide_data = ROW_DW'(s_axis_write_data_tdata) << {row_off, 3'b000};
        wide_be   = ROW_BYTES'(byte_mask) << row_off;
        wide_tgt  = ROW_BYTES'({AXIS_KEEP_WIDTH{1'b1}}) << row_off;
        for (int unsigned i = 0; i < SEG_COUNT; i++) begin
            seg_tgt[i] = |wide_tgt[i*SEG_BE_WIDTH +: SEG_BE_WIDTH];
        end
        seg_free = &(~seg_tgt | ~seg_valid_q | ram_wr_cmd_ready);
    end

    always_comb begin
        case (state_q)
            WRITE:   tready = seg_free && !abort;
            DROP:    tready = !abort;
            default: tready = 1'b0;
        endcase
    end
    assign s_axis_write_data_tready = tready;
    assign beat = s_axis_write_data_tvalid && tready;

    always_comb begin
        seg_valid_d = seg_valid_q & ~ram_wr_cmd_ready;
        seg_be_d    = seg_be_q;
        seg_addr_d  = seg_addr_q;
        seg_data_d  = seg_data_q;
        for (int unsigned i = 0; i < SEG_COUNT; i++) begin
            if (beat && state_q == WRITE && |wide_be[i*SEG_BE_WIDTH +: SEG_BE_WIDTH]) begin
                seg_valid_d[i] = 1'b1;
                seg_be_d[i*SEG_BE_WIDTH +: SEG_BE_WIDTH]       = wide_be[i*SEG_BE_WIDTH +: SEG_BE_WIDTH];
                seg_addr_d[i*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH] = word_addr;
                seg_data_d[i*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] = wide_data[i*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        tag_d      = tag_q;
        id_d       = id_q;
        dest_d     = dest_q;
        user_d     = user_q;
        first_d    = first_q;
        st_len_d   = st_len_q;
        st_tag_d   = st_tag_q;
        st_id_d    = st_id_q;
        st_dest_d  = st_dest_q;
        st_user_d  = st_user_q;
        st_err_d   = st_err_q;
        st_valid_d = 1'b0;
        desc_pop   = 1'b0;
        id_cur     = first_q ? s_axis_write_data_tid : id_q;
        dest_cur   = first_q ? s_axis_write_data_tdest : dest_q;
        user_cur   = user_q | s_axis_write_data_tuser;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && enable) begin
                    desc_pop = 1'b1;
                    addr_d   = fifo_addr_q[rd_ptr_q[FIFO_AW-1:0]];
                    rem_d    = fifo_len_q[rd_ptr_q[FIFO_AW-1:0]];
                    tag_d    = fifo_tag_q[rd_ptr_q[FIFO_AW-1:0]];
                    cnt_d    = '0;
                    user_d   = '0;
                    first_d  = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    st_valid_d = 1'b1;
                    st_len_d   = cnt_q;
                    st_tag_d   = tag_q;
                    st_id_d    = id_q;
                    st_dest_d  = dest_q;
                    st_user_d  = user_q;
                    st_err_d   = ERR_ABORT;
                    state_d    = IDLE;
                end else if (beat) begin
                    cnt_d   = cnt_q + LEN_WIDTH'(beat_bytes);
                    rem_d   = rem_q - LEN_WIDTH'(beat_bytes);
                    addr_d  = addr_q + RAM_ADDR_WIDTH'(AXIS_KEEP_WIDTH);
                    id_d    = id_cur;
                    dest_d  = dest_cur;
                    user_d  = user_cur;
                    first_d = 1'b0;
                    if (s_axis_write_data_tlast) begin
                        st_valid_d = 1'b1;
                        st_len_d   = cnt_q + LEN_WIDTH'(beat_bytes);
                        st_tag_d   = tag_q;
                        st_id_d    = id_cur;
                        st_dest_d  = dest_cur;
                        st_user_d  = user_cur;
                        st_err_d   = trunc ? ERR_TRUNC : (user_cur[0] ? ERR_USER : ERR_OK);
                        state_d    = IDLE;
                    end else if (trunc) begin
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (abort) begin
                    st_valid_d = 1'b1;
                    st_len_d   = cnt_q;
                    st_tag_d   = tag_q;
                    st_id_d    = id_q;
                    st_dest_d  = dest_q;
                    st_user_d  = user_q;
                    st_err_d   = ERR_ABORT;
                    state_d    = IDLE;
                end else if (beat) begin
                    user_d = user_cur;
                    if (s_axis_write_data_tlast) begin
                        st_valid_d = 1'b1;
                        st_len_d   = cnt_q;
                        st_tag_d   = tag_q;
                        st_id_d    = id_q;
                        st_dest_d  = dest_q;
                        st_user_d  = user_cur;
                        st_err_d   = ERR_TRUNC;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            tag_q       <= '0;
            id_q        <= '0;
            dest_q      <= '0;
            user_q      <= '0;
            first_q     <= 1'b0;
            st_len_q    <= '0;
            st_tag_q    <= '0;
            st_id_q     <= '0;
            st_dest_q   <= '0;
            st_user_q   <= '0;
            st_err_q    <= '0;
            st_valid_q  <= 1'b0;
            seg_valid_q <= '0;
            seg_be_q    <= '0;
            seg_addr_q  <= '0;
            seg_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            id_q        <= id_d;
            dest_q      <= dest_d;
            user_q      <= user_d;
            first_q     <= first_d;
            st_len_q    <= st_len_d;
            st_tag_q    <= st_tag_d;
            st_id_q     <= st_id_d;
            st_dest_q   <= st_dest_d;
            st_user_q   <= st_user_d;
            st_err_q    <= st_err_d;
            st_valid_q  <= st_valid_d;
            seg_valid_q <= seg_valid_d;
            seg_be_q    <= seg_be_d;
            seg_addr_q  <= seg_addr_d;
            seg_data_q  <= seg_data_d;
        end
    end

    assign m_axis_write_desc_status_len   = st_len_q;
    assign m_axis_write_desc_status_tag   = st_tag_q;
    assign m_axis_write_desc_status_id    = st_id_q;
    assign m_axis_write_desc_status_dest  = st_dest_q;
    assign m_axis_write_desc_status_user  = st_user_q;
    assign m_axis_write_desc_status_error = st_err_q;
    assign m_axis_write_desc_status_valid = st_valid_q;

    assign ram_wr_cmd_be    = seg_be_q;
    assign ram_wr_cmd_addr  = seg_addr_q;
    assign ram_wr_cmd_data  = seg_data_q;
    assign ram_wr_cmd_valid = seg_valid_q;

endmodule

// File: tb/tb_dma_client_axis_sink_q.sv
// Directed bench for dma_client_axis_sink_q: a vector table of single frames plus
// hand sequences for queueing, abort and descriptor-queue fill.
module tb_dma_client_axis_sink_q;

    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  desc_addr;
    logic [15:0]  desc_len;
    logic [7:0]   desc_tag;
    logic         desc_valid, desc_ready;
    logic [15:0]  st_len;
    logic [7:0]   st_tag, st_id, st_dest;
    logic [0:0]   st_user;
    logic [3:0]   st_err;
    logic         st_valid;
    logic [63:0]  tdata;
    logic [7:0]   tkeep, tid, tdest;
    logic         tvalid, tready, tlast;
    logic [0:0]   tuser;
    logic [15:0]  wr_be, wr_addr;
    logic [127:0] wr_data;
    logic [1:0]   wr_valid, wr_ready;
    logic         enable, abort;

    dma_client_axis_sink_q #(
        .SEG_COUNT(2), .SEG_DATA_WIDTH(64), .SEG_ADDR_WIDTH(8),
        .AXIS_DATA_WIDTH(64), .LEN_WIDTH(16), .TAG_WIDTH(8), .DESC_FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_write_desc_ram_addr(desc_addr), .s_axis_write_desc_len(desc_len),
        .s_axis_write_desc_tag(desc_tag), .s_axis_write_desc_valid(desc_valid),
        .s_axis_write_desc_ready(desc_ready),
        .m_axis_write_desc_status_len(st_len), .m_axis_write_desc_status_tag(st_tag),
        .m_axis_write_desc_status_id(st_id), .m_axis_write_desc_status_dest(st_dest),
        .m_axis_write_desc_status_user(st_user), .m_axis_write_desc_status_error(st_err),
        .m_axis_write_desc_status_valid(st_valid),
        .s_axis_write_data_tdata(tdata), .s_axis_write_data_tkeep(tkeep),
        .s_axis_write_data_tvalid(tvalid), .s_axis_write_data_tready(tready),
        .s_axis_write_data_tlast(tlast), .s_axis_write_data_tid(tid),
        .s_axis_write_data_tdest(tdest), .s_axis_write_data_tuser(tuser),
        .ram_wr_cmd_be(wr_be), .ram_wr_cmd_addr(wr_addr), .ram_wr_cmd_data(wr_data),
        .ram_wr_cmd_valid(wr_valid), .ram_wr_cmd_ready(wr_ready),
        .enable(enable), .abort(abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] len;
        logic [7:0]  tag, id, dest;
        logic [0:0]  user;
        logic [3:0]  err;
    } st_t;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] len;
        logic [7:0]  tag;
        int unsigned nbytes;
        logic        usr;
        int unsigned rmode;
        logic [11:0] wbase;
        logic [15:0] exp_len;
        logic [3:0]  exp_err;
    } vec_t;

    int unsigned n_pass = 0, n_total = 0;
    int unsigned rmode = 0;
    logic [7:0]  ram [4096];
    st_t         st_fifo[$];

    // RAM ready pattern: always ready, or ready one cycle in three
    initial begin
        int unsigned cyc = 0;
        wr_ready = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            wr_ready = (rmode == 0 || cyc % 3 == 0) ? 2'b11 : 2'b00;
        end
    end

    // Byte-addressed RAM image and status capture
    initial begin
        logic [11:0] ba;
        st_t s;
        for (int i = 0; i < 4096; i++) ram[i] = 8'hEE;
        forever begin
            @(negedge clk);
            for (int sg = 0; sg < 2; sg++) begin
                if (wr_valid[sg] && wr_ready[sg]) begin
                    for (int b = 0; b < 8; b++) begin
                        if (wr_be[sg*8+b]) begin
                            ba = {wr_addr[sg*8 +: 8], 1'(sg), 3'(b)};
                            ram[ba] = wr_data[sg*64+b*8 +: 8];
                        end
                    end
                end
            end
            if (st_valid) begin
                s.len = st_len; s.tag = st_tag; s.id = st_id;
                s.dest = st_dest; s.user = st_user; s.err = st_err;
                st_fifo.push_back(s);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic timeout_fail(input string nm);
        n_total++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    task automatic push_desc(input logic [11:0] a, input logic [15:0] l, input logic [7:0] t);
        int unsigned to = 0;
        @(negedge clk);
        desc_addr = a; desc_len = l; desc_tag = t; desc_valid = 1'b1;
        forever begin
            #1;
            if (desc_ready) break;
            @(negedge clk);
            if (++to > 200) begin
                timeout_fail("desc_push");
                desc_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1 desc_valid = 1'b0;
    endtask

    task automatic send_frame(input int unsigned nbytes, input logic [7:0] pb,
                              input logic [7:0] id, input logic [7:0] dst, input logic usr,
                              input int unsigned max_beats, input bit do_last);
        int unsigned nb = (nbytes + 7) / 8;
        int unsigned left, to;
        for (int unsigned b = 0; b < nb && b < max_beats; b++) begin
            @(negedge clk);
            for (int unsigned j = 0; j < 8; j++) tdata[j*8 +: 8] = pb + 8'(b*8 + j);
            left  = nbytes - b*8;
            tkeep = (left >= 8) ? 8'hFF : 8'((1 << left) - 1);
            tlast = do_last && (b == nb - 1);
            tid = id; tdest = dst; tuser = usr; tvalid = 1'b1;
            to = 0;
            forever begin
                #1;
                if (tready) break;
                @(negedge clk);
                if (++to > 300) begin
                    timeout_fail("stream_beat");
                    tvalid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
        end
        #1 tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic get_status(output st_t s, output bit ok);
        ok = 1'b0;
        s = '{default: '0};
        for (int unsigned i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (st_fifo.size() > 0) begin
                s = st_fifo.pop_front();
                ok = 1'b1;
                return;
            end
        end
        timeout_fail("status");
    endtask

    task automatic check_status(input string nm, input logic [15:0] l, input logic [7:0] t,
                                input logic [7:0] id, input logic [7:0] dst,
                                input logic usr, input logic [3:0] e);
        st_t s;
        bit  ok;
        get_status(s, ok);
        if (ok) begin
            chk({nm, "_len"}, 32'(s.len), 32'(l));
            chk({nm, "_tag"}, 32'(s.tag), 32'(t));
            chk({nm, "_id"}, 32'(s.id), 32'(id));
            chk({nm, "_dest"}, 32'(s.dest), 32'(dst));
            chk({nm, "_user"}, 32'(s.user), 32'(usr));
            chk({nm, "_err"}, 32'(s.err), 32'(e));
        end
    endtask

    // Region [base, base+n) must hold the frame pattern; the 8 bytes after must be untouched
    task automatic check_ram(input string nm, input logic [11:0] base, input int unsigned n,
                             input logic [7:0] pb);
        int unsigned bad = 0, gbad = 0;
        logic [11:0] a;
        repeat (10) @(negedge clk);
        for (int unsigned k = 0; k < n; k++) begin
            a = base + 12'(k);
            if (ram[a] !== pb + 8'(k)) bad++;
        end
        for (int unsigned k = 0; k < 8; k++) begin
            a = base + 12'(n + k);
            if (ram[a] !== 8'hEE) gbad++;
        end
        chk({nm, "_ram_bad_bytes"}, bad, 0);
        chk({nm, "_ram_guard_bad"}, gbad, 0);
    endtask

    function automatic logic [7:0] pat(input logic [7:0] tag);
        return 8'h10 + tag * 8'd4;
    endfunction

    vec_t vecs[8];

    initial begin
        vecs[0] = '{12'h200, 16'd100, 8'd3,  13, 1'b0, 0, 12'h200, 16'd13, 4'd0};
        vecs[1] = '{12'h300, 16'd16,  8'd4,  40, 1'b0, 0, 12'h300, 16'd16, 4'd1};
        vecs[2] = '{12'h400, 16'd32,  8'd5,  16, 1'b1, 0, 12'h400, 16'd16, 4'd2};
        vecs[3] = '{12'hFF8, 16'd16,  8'd6,  16, 1'b0, 0, 12'hFF8, 16'd16, 4'd0};
        vecs[4] = '{12'hC00, 16'd0,   8'd7,  8,  1'b0, 0, 12'hC00, 16'd0,  4'd1};
        vecs[5] = '{12'h505, 16'd8,   8'd8,  8,  1'b0, 0, 12'h500, 16'd8,  4'd0};
        vecs[6] = '{12'hD00, 16'd24,  8'd9,  24, 1'b0, 1, 12'hD00, 16'd24, 4'd0};
        vecs[7] = '{12'hE00, 16'd20,  8'd12, 24, 1'b0, 0, 12'hE00, 16'd20, 4'd1};

        rst = 1'b1; enable = 1'b0; abort = 1'b0;
        desc_valid = 1'b0; desc_addr = '0; desc_len = '0; desc_tag = '0;
        tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; tid = '0; tdest = '0; tuser = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_desc_ready", 32'(desc_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_desc_ready_after", 32'(desc_ready), 1);
        chk("rst_tready", 32'(tready), 0);
        chk("rst_status_valid", 32'(st_valid), 0);
        chk("rst_status_len", 32'(st_len), 0);
        chk("rst_status_err", 32'(st_err), 0);
        chk("rst_ram_valid", 32'(wr_valid), 0);

        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rmode = vecs[i].rmode;
            push_desc(vecs[i].addr, vecs[i].len, vecs[i].tag);
            send_frame(vecs[i].nbytes, pat(vecs[i].tag), vecs[i].tag + 8'h40,
                       vecs[i].tag + 8'h80, vecs[i].usr, 1000, 1'b1);
            check_status($sformatf("vec%0d", i), vecs[i].exp_len, vecs[i].tag,
                         vecs[i].tag + 8'h40, vecs[i].tag + 8'h80, vecs[i].usr, vecs[i].exp_err);
            check_ram($sformatf("vec%0d", i), vecs[i].wbase, vecs[i].exp_len, pat(vecs[i].tag));
            rmode = 0;
        end

        // Two descriptors queued ahead of data, frames back to back
        push_desc(12'h000, 16'd64, 8'd1);
        push_desc(12'h100, 16'd24, 8'd2);
        send_frame(64, pat(8'd1), 8'h21, 8'h31, 1'b0, 1000, 1'b1);
        @(negedge clk);
        #1;
        chk("b2b_idle_gap_tready", 32'(tready), 0);
        @(negedge clk);
        #1;
        chk("b2b_second_ready", 32'(tready), 1);
        send_frame(24, pat(8'd2), 8'h22, 8'h32, 1'b0, 1000, 1'b1);
        check_status("q1", 16'd64, 8'd1, 8'h21, 8'h31, 1'b0, 4'd0);
        check_status("q2", 16'd24, 8'd2, 8'h22, 8'h32, 1'b0, 4'd0);
        check_ram("q1", 12'h000, 64, pat(8'd1));
        check_ram("q2", 12'h100, 24, pat(8'd2));

        // Abort after two beats, then a clean frame
        push_desc(12'h600, 16'd64, 8'd13);
        send_frame(64, pat(8'd13), 8'h23, 8'h33, 1'b0, 2, 1'b0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_status("abort", 16'd16, 8'd13, 8'h23, 8'h33, 1'b0, 4'd3);
        check_ram("abort", 12'h600, 16, pat(8'd13));
        push_desc(12'h700, 16'd8, 8'd14);
        send_frame(8, pat(8'd14), 8'h24, 8'h34, 1'b0, 1000, 1'b1);
        check_status("post_abort", 16'd8, 8'd14, 8'h24, 8'h34, 1'b0, 4'd0);
        check_ram("post_abort", 12'h700, 8, pat(8'd14));

        // Fill the descriptor queue while disabled
        enable = 1'b0;
        for (int unsigned i = 0; i < 4; i++) push_desc(12'h800 + 12'(i * 12'h100), 16'd8, 8'(15 + i));
        @(negedge clk);
        #1;
        chk("full_desc_ready", 32'(desc_ready), 0);
        chk("full_no_start_tready", 32'(tready), 0);
        enable = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            send_frame(8, pat(8'(15 + i)), 8'(8'h50 + i), 8'(8'h60 + i), 1'b0, 1000, 1'b1);
        end
        for (int unsigned i = 0; i < 4; i++) begin
            check_status($sformatf("fill%0d", i), 16'd8, 8'(15 + i), 8'(8'h50 + i),
                         8'(8'h60 + i), 1'b0, 4'd0);
        end
        check_ram("fill3", 12'hB00, 8, pat(8'd18));
        chk("drained_desc_ready", 32'(desc_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
